// File: rtl/regbank_dbg_pkg.sv
// Shared build-time constants, op/bank codes and FSM state encodings for the
// regbank debug port.
`ifndef REGBANK_DBG_DEFINES
`define REGBANK_DBG_DEFINES
`define WIDTH         32
`define REG_SEL       4
`define NUM_REGS      16
`define NUM_PRED_REGS 8
`define PRED_REG_SEL  3
`define PRED_WIDTH    1
`define S_REGS        1'b0
`define P_REGS        1'b1
`define DBG_RD        2'b00
`define DBG_WR        2'b01
`define DBG_DUMP      2'b10
`endif

package regbank_dbg_pkg;

  localparam int DATA_W = `WIDTH;
  localparam int SEL_W  = `REG_SEL;
  localparam int PRED_W = `PRED_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    REQ    = ST_REQ,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_e;

  // Highest register index of a bank; marks the final beat of a dump.
  function automatic logic [SEL_W-1:0] last_idx(input logic bank);
    return (bank == `P_REGS) ? SEL_W'(`NUM_PRED_REGS - 1) : SEL_W'(`NUM_REGS - 1);
  endfunction

endpackage

// File: rtl/regbank_dbg.sv
// Debug access port to the core register bank: single read/write and whole-bank
// dump, borrowing the regbank ports from the core via a req/grant handshake.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// REQ    | requesting regbank ownership, waiting for dbg_grant
// ACCESS | one-cycle regbank read or write
// RESP   | response held on rsp_* until rsp_ready
module regbank_dbg
  import regbank_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_bank,
  input  logic [SEL_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [SEL_W-1:0]  rsp_addr,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              dbg_req,
  input  logic              dbg_grant,
  output logic [SEL_W-1:0]  rb_a_addr,
  output logic              rb_a_sel,
  input  logic [DATA_W-1:0] rb_a_data,
  output logic              rb_write_enable,
  output logic [SEL_W-1:0]  rb_z_addr,
  output logic              rb_z_sel,
  output logic [DATA_W-1:0] rb_z_data,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                bank_q, bank_d;
  logic [SEL_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [SEL_W-1:0]    rsp_addr_q, rsp_addr_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_err_q, rsp_err_d;
  logic                ready_q;

  logic                cmd_bad;
  logic [SEL_W-1:0]    acc_addr;
  logic                in_access;
  logic                is_wr;

  // Dumps ignore cmd_addr, so only single accesses can hit a missing P register.
  assign cmd_bad  = (cmd_op == 2'b11) ||
                    ((cmd_bank == `P_REGS) && (cmd_op != `DBG_DUMP) &&
                     (cmd_addr >= SEL_W'(`NUM_PRED_REGS)));
  assign acc_addr = (op_q == `DBG_DUMP) ? idx_q : addr_q;
  assign is_wr    = (op_q == `DBG_WR);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          bank_d = cmd_bank;
          addr_d = cmd_addr;
          data_d = cmd_data;
          idx_d  = '0;
          err_d  = cmd_bad;
          if (cmd_bad) begin
            rsp_data_d = '0;
            rsp_addr_d = cmd_addr;
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dbg_grant) state_d = ACCESS;
      end
      ACCESS: begin
        rsp_addr_d = acc_addr;
        rsp_err_d  = 1'b0;
        rsp_last_d = (op_q != `DBG_DUMP) || (idx_q == last_idx(bank_q));
        if (is_wr)
          rsp_data_d = data_q;
        else if (bank_q == `P_REGS)
          rsp_data_d = {{(DATA_W-PRED_W){1'b0}}, rb_a_data[PRED_W-1:0]};
        else
          rsp_data_d = rb_a_data;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if ((op_q == `DBG_DUMP) && !rsp_last_q) begin
            idx_d   = idx_q + 1'b1;
            state_d = dbg_grant ? ACCESS : REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      bank_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
      ready_q    <= 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE) && ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_req   = busy && !err_q;

  // Regbank drive is qualified by grant so the core owns the ports otherwise.
  assign in_access       = (state_q == ACCESS) && dbg_grant && !err_q;
  assign rb_a_addr       = (in_access && !is_wr) ? acc_addr : '0;
  assign rb_a_sel        = in_access && !is_wr && bank_q;
  assign rb_write_enable = in_access && is_wr;
  assign rb_z_addr       = rb_write_enable ? addr_q : '0;
  assign rb_z_sel        = rb_write_enable && bank_q;
  assign rb_z_data       = rb_write_enable ? data_q : '0;

endmodule

// File: tb/tb_regbank_dbg.sv
// Scoreboard bench for regbank_dbg with a behavioural register bank attached;
// stimulus queues expected beats, a negedge monitor consumes and checks them.
module tb_regbank_dbg;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
  localparam logic       BANK_S  = 1'b0;
  localparam logic       BANK_P  = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_bank;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_addr;
  logic        rsp_last, rsp_err;
  logic        dbg_req, dbg_grant;
  logic [3:0]  rb_a_addr;
  logic        rb_a_sel;
  logic [31:0] rb_a_data;
  logic        rb_write_enable;
  logic [3:0]  rb_z_addr;
  logic        rb_z_sel;
  logic [31:0] rb_z_data;
  logic        busy;

  always #5 clk = ~clk;

  regbank_dbg dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .dbg_req(dbg_req), .dbg_grant(dbg_grant),
    .rb_a_addr(rb_a_addr), .rb_a_sel(rb_a_sel), .rb_a_data(rb_a_data),
    .rb_write_enable(rb_write_enable), .rb_z_addr(rb_z_addr), .rb_z_sel(rb_z_sel),
    .rb_z_data(rb_z_data), .busy(busy)
  );

  // Register bank: 16 x 32 S regs, 8 x 1-bit P regs; junk in upper P read bits.
  logic [31:0] s_mem [16];
  logic        p_mem [8];
  int          write_cnt = 0;

  assign rb_a_data = rb_a_sel ? {8'hC3, 23'h0, p_mem[rb_a_addr[2:0]]} : s_mem[rb_a_addr];

  always @(posedge clk) begin
    if (rb_write_enable) begin
      if (rb_z_sel) p_mem[rb_z_addr[2:0]] <= rb_z_data[0];
      else          s_mem[rb_z_addr]      <= rb_z_data;
      write_cnt <= write_cnt + 1;
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  addr;
    logic        last;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] a, input logic l, input logic e);
    rsp_t r;
    r.data = d; r.addr = a; r.last = l; r.err = e;
    exp_q.push_back(r);
  endtask

  // Monitor: checks each handshaked beat and payload stability during stalls.
  rsp_t mon_e;
  rsp_t held;
  logic held_v = 1'b0;
  logic req_seen = 1'b0;

  always @(negedge clk) begin
    if (dbg_req) req_seen = 1'b1;
    if (reset) begin
      held_v = 1'b0;
    end else if (rsp_valid) begin
      if (held_v)
        check("stall_stable", 64'({rsp_data, rsp_addr, rsp_last, rsp_err}), 64'(held));
      if (rsp_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual addr=%0h data=%0h required none", rsp_addr, rsp_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
          check("rsp_addr", 64'(rsp_addr), 64'(mon_e.addr));
          check("rsp_last", 64'(rsp_last), 64'(mon_e.last));
          check("rsp_err",  64'(rsp_err),  64'(mon_e.err));
        end
      end else begin
        held   = {rsp_data, rsp_addr, rsp_last, rsp_err};
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one cycle after the accepting edge (DUT is then in its first post-IDLE state).
  task automatic send(input logic [1:0] op, input logic bank, input logic [3:0] addr,
                      input logic [31:0] data);
    bit ok = 0;
    cmd_op = op; cmd_bank = bank; cmd_addr = addr; cmd_data = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_beat(input logic [3:0] a, input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid && rsp_addr == a) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_beat required beat %0d", name, a);
    end
  endtask

  // Acceptance cycle is cycle 0; rsp_valid must appear at cycle 3.
  task automatic check_latency(input string name);
    logic [2:0] v;
    v[2] = rsp_valid;
    tick();
    v[1] = rsp_valid;
    tick();
    v[0] = rsp_valid;
    check(name, 64'(v), 64'(3'b001));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic req_all, we_any, hold_ok, any_valid;
    int   wc;
    for (int i = 0; i < 16; i++) s_mem[i] = 32'h0;
    for (int i = 0; i < 8; i++)  p_mem[i] = 1'b0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_bank = 1'b0;
    cmd_addr = 4'h0; cmd_data = 32'h0; rsp_ready = 1'b1; dbg_grant = 1'b1;
    tick(3);

    // Reset state
    check("reset_outputs",
          64'({cmd_ready, busy, rsp_valid, dbg_req, rb_write_enable, rb_a_sel, rb_z_sel,
               rsp_last, rsp_err, rsp_addr, rb_a_addr, rb_z_addr}), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    reset = 1'b0;
    check("ready_at_deassert", 64'(cmd_ready), 64'(0));
    tick();
    check("ready_after_deassert", 64'(cmd_ready), 64'(1));

    // Write S[5] then read it back, grant tied high
    push(32'hDEADBEEF, 4'd5, 1'b1, 1'b0);
    send(OP_WR, BANK_S, 4'd5, 32'hDEADBEEF);
    check_latency("wr_latency");
    wait_drain("wr_s5");
    check("wr_pulse_count", 64'(write_cnt), 64'(1));
    push(32'hDEADBEEF, 4'd5, 1'b1, 1'b0);
    send(OP_RD, BANK_S, 4'd5, 32'h0);
    check_latency("rd_latency");
    wait_drain("rd_s5");

    // Fill S[i]=i*3 and dump with rsp_ready toggling
    for (int i = 0; i < 16; i++) begin
      push(32'(i * 3), 4'(i), 1'b1, 1'b0);
      send(OP_WR, BANK_S, 4'(i), 32'(i * 3));
      wait_drain("fill_s");
    end
    for (int i = 0; i < 16; i++) push(32'(i * 3), 4'(i), i == 15, 1'b0);
    send(OP_DUMP, BANK_S, 4'd0, 32'h0);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      rsp_ready = ~rsp_ready;
      tick();
    end
    rsp_ready = 1'b1;
    wait_drain("dump_s");

    // Illegal accesses: P index out of range, reserved op
    req_seen = 1'b0;
    push(32'h0, 4'd9, 1'b1, 1'b1);
    send(OP_RD, BANK_P, 4'd9, 32'h0);
    wait_drain("rd_p9");
    check("err_no_dbg_req", 64'(req_seen), 64'(0));
    push(32'h0, 4'd2, 1'b1, 1'b1);
    send(OP_RSV, BANK_S, 4'd2, 32'h1234);
    wait_drain("rsv_op");

    // Write stalled on grant for 10 cycles
    dbg_grant = 1'b0;
    push(32'h12345678, 4'd7, 1'b1, 1'b0);
    send(OP_WR, BANK_S, 4'd7, 32'h12345678);
    req_all = 1'b1;
    we_any  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_all &= dbg_req;
      we_any  |= rb_write_enable;
      tick();
    end
    check("nogrant_req_held", 64'(req_all), 64'(1));
    check("nogrant_no_write", 64'(we_any), 64'(0));
    dbg_grant = 1'b1;
    tick();
    check("write_after_grant", 64'(rb_write_enable), 64'(1));
    wait_drain("wr_s7");
    push(32'h12345678, 4'd7, 1'b1, 1'b0);
    send(OP_RD, BANK_S, 4'd7, 32'h0);
    wait_drain("rd_s7");

    // Fill P[i] with low bit i&1, then dump with grant drop and mid-dump reset
    for (int i = 0; i < 8; i++) begin
      push(32'hF0 + 32'(i), 4'(i), 1'b1, 1'b0);
      send(OP_WR, BANK_P, 4'(i), 32'hF0 + 32'(i));
      wait_drain("fill_p");
    end
    check("write_total", 64'(write_cnt), 64'(26));
    for (int i = 0; i < 6; i++) push(32'(i & 1), 4'(i), 1'b0, 1'b0);
    send(OP_DUMP, BANK_P, 4'd0, 32'h0);
    wait_beat(4'd3, "p_beat3");
    dbg_grant = 1'b0;
    tick();
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hold_ok &= busy && dbg_req && !rsp_valid && !rb_a_sel && (rb_a_addr == 4'd0);
      tick();
    end
    check("grant_drop_hold", 64'(hold_ok), 64'(1));
    dbg_grant = 1'b1;
    wait_beat(4'd5, "p_beat5");
    tick();
    rsp_ready = 1'b0;
    wait_beat(4'd6, "p_beat6");
    check("p_beat6_addr", 64'(rsp_addr), 64'(6));
    wc = write_cnt;
    reset = 1'b1;
    tick();
    check("reset_abort_idle", 64'({busy, rsp_valid, dbg_req, cmd_ready}), 64'(0));
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      any_valid |= rsp_valid;
      tick();
    end
    check("no_beats_after_reset", 64'(any_valid), 64'(0));
    check("dump_beats_0_to_5", 64'(exp_q.size()), 64'(0));
    check("no_write_on_abort", 64'(write_cnt), 64'(wc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
